// File: rtl/iob_wr_burst_gather_pkg.sv
// Shared types and constants for the write-combining gather stage.
// AXI_LEN_W mirrors the common AXI header (AXI4 8-bit burst length).
package iob_wr_burst_gather_pkg;

  localparam int AXI_LEN_W = 8;
  localparam logic [11:0] BOUND_MASK = 12'hfff;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    SEND   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/iob_wr_burst_gather_buf.sv
// Register-array FIFO holding {data, strobe} beats of one burst.
// Depth must be a power of two so the pointers wrap naturally.
module iob_gather_buf #(
  parameter int W     = 36,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  assign head = mem[rp];

endmodule

// File: rtl/iob_wr_burst_gather.sv
// Gathers sequential single-beat writes into INCR bursts for the burst master.
// Define IOB_WR_GATHER_TIMEOUT_EN to launch partial bursts after TIMEOUT idle cycles.
module iob_wr_burst_gather
  import iob_wr_burst_gather_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 u_valid,
  input  logic [ADDR_W-1:0]    u_addr,
  input  logic [DATA_W-1:0]    u_wdata,
  input  logic [DATA_W/8-1:0]  u_wstrb,
  output logic                 u_ready,
  input  logic                 flush,
  output logic [AXI_LEN_W-1:0] m_length,
  input  logic                 m_idle,
  input  logic                 m_error,
  output logic                 m_valid,
  output logic [ADDR_W-1:0]    m_addr,
  output logic [DATA_W-1:0]    m_wdata,
  output logic [DATA_W/8-1:0]  m_wstrb,
  input  logic                 m_ready,
  output logic                 error,
  output logic                 busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int SH    = $clog2(BYTES);
  localparam int CW    = $clog2(BURST_MAX) + 1;

  state_t               state;
  state_t               state_nx;
  logic [CW-1:0]        count;
  logic [CW-1:0]        cnt_nx;
  logic [ADDR_W-1:0]    base;
  logic [AXI_LEN_W-1:0] len_q;
  logic                 err_q;
  logic                 push;
  logic                 pop;
  logic                 launch;
  logic                 seq;
  logic                 nonseq;
  logic                 full;
  logic                 bound;
  logic                 tmo;
  logic                 trig;
  logic [11:0]          nxt_lo;

  assign seq = u_addr == base + (ADDR_W'(count) << SH);

  assign u_ready = u_valid && state == FILL &&
                   count < CW'(BURST_MAX) &&
                   (count == '0 || seq) && !flush;

  assign push   = u_ready;
  assign cnt_nx = count + CW'(push);

  // Low 12 bits of the address the next sequential beat would use.
  assign nxt_lo = (count == '0 ? u_addr[11:0] : base[11:0])
                + 12'(ADDR_W'(cnt_nx) << SH);

  assign bound  = (nxt_lo & BOUND_MASK) == '0;
  assign nonseq = count != '0 && u_valid && !seq;
  assign full   = cnt_nx == CW'(BURST_MAX);
  assign trig   = full || flush || nonseq || bound || tmo;

`ifdef IOB_WR_GATHER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
    end else if (state != FILL || count == '0 || push) begin
      idle_q <= '0;
    end else if (!tmo) begin
      idle_q <= idle_q + TW'(1);
    end
  end

  assign tmo = !push && count != '0 &&
               idle_q == TW'(TIMEOUT - 1);
`else
  assign tmo = TIMEOUT < 0;
`endif

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    unique case (state)
      FILL: begin
        if (cnt_nx != '0 && trig) begin
          state_nx = LAUNCH;
          launch   = 1'b1;
        end
      end
      LAUNCH: if (m_idle) state_nx = SEND;
      SEND:   if (pop && count == CW'(1)) state_nx = DONE;
      DONE:   if (m_idle) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      base  <= '0;
      len_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (push && count == '0) base <= u_addr;
      if (launch) len_q <= AXI_LEN_W'(cnt_nx - CW'(1));
      if (state == DONE && m_idle) err_q <= err_q | m_error;
    end
  end

  assign m_valid  = state == SEND && count != '0;
  assign pop      = m_valid && m_ready;
  assign m_addr   = base;
  assign m_length = len_q;
  assign error    = err_q;
  assign busy     = state != FILL || count != '0;

  iob_gather_buf #(
    .W     (DATA_W + BYTES),
    .DEPTH (BURST_MAX)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({u_wdata, u_wstrb}),
    .head  ({m_wdata, m_wstrb}),
    .count (count)
  );

endmodule

// File: tb/tb_iob_wr_burst_gather.sv
// Directed and random stimulus for iob_wr_burst_gather against a burst-level model.
// Expects beats in order with the burst base and length they were launched with.
module tb_iob_wr_burst_gather;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        u_valid;
  logic [31:0] u_addr;
  logic [31:0] u_wdata;
  logic [3:0]  u_wstrb;
  logic        u_ready;
  logic        flush;
  logic [7:0]  m_length;
  logic        m_idle;
  logic        m_error;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic        error;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  bit rand_rdy = 1'b0;
  bit mon_en = 1'b1;

  beat_t exp_q[$];
  beat_t got_q[$];
  beat_t pend[$];
  logic [31:0] cur_base = '0;
  int cur_cnt = 0;

  always #5 clk = ~clk;

  iob_wr_burst_gather #(
    .ADDR_W(32), .DATA_W(32), .BURST_MAX(16), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .u_valid(u_valid), .u_addr(u_addr),
    .u_wdata(u_wdata), .u_wstrb(u_wstrb),
    .u_ready(u_ready), .flush(flush),
    .m_length(m_length), .m_idle(m_idle),
    .m_error(m_error), .m_valid(m_valid),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_ready(m_ready),
    .error(error), .busy(busy)
  );

  // Downstream side: pick m_ready at the falling edge and log the beat
  // that the next rising edge will transfer.
  always @(negedge clk) begin
    if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
    if (mon_en && m_valid && m_ready)
      got_q.push_back('{m_addr, m_length, m_wdata, m_wstrb});
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mdl_close();
    foreach (pend[i]) begin
      pend[i].len = 8'(cur_cnt - 1);
      exp_q.push_back(pend[i]);
    end
    pend.delete();
    cur_cnt = 0;
  endtask

  task automatic mdl_push(input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s);
    if (cur_cnt > 0 && a != cur_base + 32'(4 * cur_cnt)) mdl_close();
    if (cur_cnt == 0) cur_base = a;
    pend.push_back('{cur_base, 8'h0, d, s});
    cur_cnt++;
    if (cur_cnt == 16 || ((cur_base + 32'(4 * cur_cnt)) & 32'hfff) == 0)
      mdl_close();
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    u_valid = 1'b1;
    u_addr = a;
    u_wdata = d;
    u_wstrb = s;
    #1;
    while (!u_ready && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 500) chk("wr_accept_timeout", 128'(n), 128'(0));
    @(posedge clk);
    mdl_push(a, d, s);
    #1;
    u_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    if (cur_cnt > 0) mdl_close();
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((got_q.size() != exp_q.size() || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk(tag, 128'(n), 128'(0));
  endtask

  task automatic check_beats(input string tag);
    int n;
    chk({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    n = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk({tag, "_beat"}, 128'(got_q[i]), 128'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic run(input logic [31:0] a, input int len);
    for (int i = 0; i < len; i++)
      wr(a + 32'(4 * i), $urandom, 4'($urandom_range(0, 15)));
  endtask

  initial begin
    logic [31:0] b;
    rst = 1'b1;
    u_valid = 1'b0;
    u_addr = '0;
    u_wdata = '0;
    u_wstrb = '0;
    flush = 1'b0;
    m_idle = 1'b1;
    m_error = 1'b0;
    m_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_m_valid", 128'(m_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_error", 128'(error), 128'(0));
    chk("rst_m_length", 128'(m_length), 128'(0));
    chk("rst_m_addr", 128'(m_addr), 128'(0));
    chk("rst_u_ready", 128'(u_ready), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    u_valid = 1'b1;
    u_addr = 32'h100;
    #1;
    chk("idle_u_ready", 128'(u_ready), 128'(1));
    u_valid = 1'b0;

    // full 16-beat burst with m_ready held high
    for (int i = 0; i < 16; i++)
      wr(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hf);
    wait_drain("full_drain");
    chk("full_first_addr", 128'(got_q.size() > 0 ? got_q[0].addr : '0),
        128'(32'h100));
    chk("full_first_len", 128'(got_q.size() > 0 ? got_q[0].len : '0),
        128'(15));
    check_beats("full");

    rand_rdy = 1'b1;

    // discontinuity stalls the new address until the burst completes
    wr(32'h200, 32'h1, 4'h1);
    wr(32'h204, 32'h2, 4'h3);
    wr(32'h208, 32'h3, 4'h7);
    @(negedge clk);
    u_valid = 1'b1;
    u_addr = 32'h400;
    #1;
    chk("disc_u_ready", 128'(u_ready), 128'(0));
    wr(32'h400, 32'h4, 4'hf);
    do_flush();
    wait_drain("disc_drain");
    check_beats("disc");

    // 4 KB boundary launches without a further write
    wr(32'hff8, 32'h11, 4'hf);
    wr(32'hffc, 32'h12, 4'he);
    wait_drain("bound_drain");
    check_beats("bound");
    wr(32'h1000, 32'h13, 4'hf);
    do_flush();
    wait_drain("bound2_drain");
    check_beats("bound2");

    // flush with five buffered, then with none
    run(32'h2000, 5);
    do_flush();
    wait_drain("flush5_drain");
    check_beats("flush5");
    do_flush();
    repeat (10) @(negedge clk);
    chk("flush0_beats", 128'(got_q.size()), 128'(0));
    chk("flush0_busy", 128'(busy), 128'(0));

    // master not idle holds the burst in LAUNCH
    m_idle = 1'b0;
    run(32'h2100, 2);
    do_flush();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("launch_hold_m_valid", 128'(m_valid), 128'(0));
    end
    chk("launch_hold_busy", 128'(busy), 128'(1));
    m_idle = 1'b1;
    wait_drain("launch_drain");
    check_beats("launch");

    // partial burst left idle
    run(32'h2200, 2);
    repeat (20) @(negedge clk);
`ifdef IOB_WR_GATHER_TIMEOUT_EN
    mdl_close();
    chk("idle_timeout_beats", 128'(got_q.size()), 128'(2));
`else
    chk("idle_no_launch", 128'(got_q.size()), 128'(0));
    do_flush();
`endif
    wait_drain("idle_drain");
    check_beats("idle");

    // random runs with random flushes and boundary approaches
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 3) == 0)
        b = ($urandom & 32'hffff_f000) + 32'h1000
          - 32'(4 * $urandom_range(1, 6));
      else
        b = $urandom & 32'hffff_fffc;
      run(b, $urandom_range(1, 20));
      if ($urandom_range(0, 1) == 1) do_flush();
    end
    do_flush();
    wait_drain("rand_drain");
    check_beats("rand");

    // sticky error
    m_error = 1'b1;
    run(32'h3000, 3);
    do_flush();
    wait_drain("err_drain");
    m_error = 1'b0;
    check_beats("err");
    chk("err_set", 128'(error), 128'(1));
    run(32'h3100, 2);
    do_flush();
    wait_drain("err2_drain");
    check_beats("err2");
    chk("err_sticky", 128'(error), 128'(1));

    // reset in the middle of SEND
    rand_rdy = 1'b0;
    mon_en = 1'b0;
    m_ready = 1'b0;
    run(32'h4000, 4);
    do_flush();
    begin
      int n = 0;
      while (!m_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("send_reached", 128'(m_valid), 128'(1));
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_send_m_valid", 128'(m_valid), 128'(0));
    chk("rst_send_busy", 128'(busy), 128'(0));
    chk("rst_send_error", 128'(error), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    pend.delete();
    cur_cnt = 0;
    mon_en = 1'b1;
    m_ready = 1'b1;
    run(32'h5000, 3);
    do_flush();
    wait_drain("post_rst_drain");
    check_beats("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
